// File: rtl/poly_t1_pack_pkg.sv
// Shared constants for the public-key packers: polynomial geometry, stream word width
// and the packer state encoding.
package poly_t1_pack_pkg;

    localparam int N       = 256;
    localparam int T1_BITS = 10;
    localparam int WORD_W  = 32;
    localparam int COEF_W  = 32;
    localparam int A_W     = N * COEF_W;
    localparam int P_W     = N * T1_BITS;
    localparam int NWORDS  = P_W / WORD_W;
    localparam int CNT_W   = 7;
    localparam int BASE_W  = 12;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Bit offset of word idx inside the packed vector.
    function automatic logic [BASE_W-1:0] word_base(input logic [CNT_W-1:0] idx);
        return BASE_W'(idx) * BASE_W'(WORD_W);
    endfunction

endpackage

// File: rtl/poly_t1_pack_comb.sv
// Combinational slice of the 256 signed 32-bit coefficients down to their low 10 bits,
// plus the out-of-range flag over the whole polynomial.
module t1_pack_comb
    import poly_t1_pack_pkg::*;
(
    input  logic [A_W-1:0] linear_a1,
    output logic [P_W-1:0] packed_vec,
    output logic           range_err
);

    logic [N-1:0] oor;

    for (genvar gi = 0; gi < N; gi++) begin : g_coef
        logic [COEF_W-1:0] coef;
        assign coef = linear_a1[gi*COEF_W +: COEF_W];
        assign packed_vec[gi*T1_BITS +: T1_BITS] = coef[T1_BITS-1:0];
        // Negative (sign bit) or any magnitude bit above 1023 is out of range.
        assign oor[gi] = coef[COEF_W-1] | (|coef[COEF_W-2:T1_BITS]);
    end

    assign range_err = |oor;

endmodule

// File: rtl/poly_t1_pack.sv
// t1 public-key packer: latches one polynomial as a 2560-bit vector and streams it out
// as 80 little-endian 32-bit words over valid/ready, then pulses done.
module poly_t1_pack
    import poly_t1_pack_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              in_ready,
    input  logic [A_W-1:0]    linear_a1,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done,
    output logic              range_err
);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic [P_W-1:0]    packed_reg;
    logic [WORD_W-1:0] out_data_reg;
    logic              out_valid_reg;
    logic              out_last_reg;
    logic              done_reg;
    logic              range_err_reg;

    logic [P_W-1:0]    packed_comb;
    logic              range_err_comb;

    t1_pack_comb u_comb (
        .linear_a1  (linear_a1),
        .packed_vec (packed_comb),
        .range_err  (range_err_comb)
    );

    assign cnt_next = cnt_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            packed_reg    <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            done_reg      <= 1'b0;
            range_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        packed_reg    <= packed_comb;
                        range_err_reg <= range_err_comb;
                        cnt_reg       <= '0;
                        out_data_reg  <= packed_comb[WORD_W-1:0];
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= 1'b0;
                        state_reg     <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    // Outputs only move on a handshake, so a stalled word holds stable.
                    if (out_ready) begin
                        if (cnt_reg == LAST_CNT) begin
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            out_data_reg  <= '0;
                            done_reg      <= 1'b1;
                            state_reg     <= ST_DONE;
                        end else begin
                            cnt_reg      <= cnt_next;
                            out_data_reg <= packed_reg[word_base(cnt_next) +: WORD_W];
                            out_last_reg <= (cnt_next == LAST_CNT);
                        end
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    cnt_reg   <= '0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign done      = done_reg;
    assign range_err = range_err_reg;

endmodule

// File: tb/tb_poly_t1_pack.sv
// Bench for poly_t1_pack: directed vector table, random packets with random stalls,
// start-during-stream and mid-stream reset, all checked against a bit-level model.
module tb_poly_t1_pack;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_ready;
    logic [8191:0] linear_a1;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          done;
    logic          range_err;

    poly_t1_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_ready  (in_ready),
        .linear_a1 (linear_a1),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .done      (done),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int          coef [256];
    logic [31:0] exp_words [80];
    logic        exp_err;

    typedef struct {
        int          mode;
        logic [31:0] w0;
        logic        err;
        int          stall;
        int          inject;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-stream bit b holds bit (b mod 10) of coefficient b/10.
    task automatic build_model();
        exp_err = 1'b0;
        for (int i = 0; i < 256; i++)
            if (coef[i] < 0 || coef[i] > 1023) exp_err = 1'b1;
        for (int k = 0; k < 80; k++) begin
            exp_words[k] = '0;
            for (int m = 0; m < 32; m++) begin
                int b;
                b = 32 * k + m;
                exp_words[k][m] = ((coef[b / 10] >>> (b % 10)) & 1) != 0;
            end
        end
    endtask

    task automatic set_coef(input int mode);
        for (int i = 0; i < 256; i++) begin
            case (mode)
                0: coef[i] = i % 1024;
                1: coef[i] = 1023;
                2: coef[i] = 0;
                3: coef[i] = (i == 5) ? 1024 : 0;
                default: begin
                    if ($urandom_range(0, 15) == 0) coef[i] = int'($urandom);
                    else coef[i] = int'($urandom_range(0, 1023));
                end
            endcase
        end
        build_model();
    endtask

    task automatic drive_bus(input logic alt);
        for (int i = 0; i < 256; i++)
            linear_a1[32*i +: 32] = alt ? 32'h0000_0155 : coef[i];
    endtask

    task automatic run_packet(input string tag, input int stall, input int inject_at,
                              input int abort_at, output logic [31:0] w0, output logic err0);
        int          guard;
        int          got;
        int          cycles;
        logic        rdy;
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        w0 = '0;
        err0 = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        drive_bus(1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        cycles = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        while (got < 80 && cycles < 2000) begin
            if (abort_at >= 0 && got == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, " rst_valid"}, 32'(out_valid), 32'd0);
                chk({tag, " rst_in_ready"}, 32'(in_ready), 32'd1);
                chk({tag, " rst_data"}, out_data, 32'd0);
                chk({tag, " rst_err"}, 32'(range_err), 32'd0);
                @(negedge clk);
                chk({tag, " rst_done"}, 32'(done), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                $display("packet %s: reset after %0d words", tag, got);
                return;
            end
            chk({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
            chk({tag, " done_early"}, 32'(done), 32'd0);
            chk({tag, " valid"}, 32'(out_valid), 32'd1);
            chk({tag, " range_err"}, 32'(range_err), 32'(exp_err));
            if (got == 0) err0 = range_err;
            if (prev_stall) begin
                chk({tag, " stall_data"}, out_data, prev_data);
                chk({tag, " stall_last"}, 32'(out_last), 32'(prev_last));
            end
            if (got == inject_at && cycles == inject_at) begin
                drive_bus(1'b1);
                start = 1'b1;
            end else begin
                drive_bus(1'b0);
                start = 1'b0;
            end
            rdy = (stall != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            if (rdy) begin
                chk({tag, " word"}, out_data, exp_words[got]);
                chk({tag, " last"}, 32'(out_last), 32'(got == 79));
                if (got == 0) w0 = out_data;
                got++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                prev_data = out_data;
                prev_last = out_last;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk({tag, " word_count"}, 32'(got), 32'd80);
        if (stall == 0) chk({tag, " throughput"}, 32'(cycles), 32'd80);
        chk({tag, " valid_after"}, 32'(out_valid), 32'd0);
        chk({tag, " done_pulse"}, 32'(done), 32'd1);
        @(negedge clk);
        chk({tag, " done_clear"}, 32'(done), 32'd0);
        chk({tag, " in_ready_back"}, 32'(in_ready), 32'd1);
        $display("packet %s: %0d words in %0d cycles, word0=%h range_err=%0d",
                 tag, got, cycles, w0, range_err);
    endtask

    initial begin
        logic [31:0] w0;
        logic        e0;
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        linear_a1 = '0;
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset valid", 32'(out_valid), 32'd0);
        chk("reset last", 32'(out_last), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(range_err), 32'd0);
        chk("reset data", out_data, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        tbl[0] = '{mode: 0, w0: 32'hC020_0400, err: 1'b0, stall: 0, inject: -1};
        tbl[1] = '{mode: 1, w0: 32'hFFFF_FFFF, err: 1'b0, stall: 0, inject: -1};
        tbl[2] = '{mode: 2, w0: 32'h0000_0000, err: 1'b0, stall: 0, inject: -1};
        tbl[3] = '{mode: 3, w0: 32'h0000_0000, err: 1'b1, stall: 0, inject: -1};
        tbl[4] = '{mode: 0, w0: 32'hC020_0400, err: 1'b0, stall: 1, inject: -1};
        tbl[5] = '{mode: 0, w0: 32'hC020_0400, err: 1'b0, stall: 0, inject: 10};

        for (int v = 0; v < 6; v++) begin
            set_coef(tbl[v].mode);
            run_packet($sformatf("vec%0d", v), tbl[v].stall, tbl[v].inject, -1, w0, e0);
            chk($sformatf("vec%0d word0", v), w0, tbl[v].w0);
            chk($sformatf("vec%0d err", v), 32'(e0), 32'(tbl[v].err));
        end

        for (int r = 0; r < 8; r++) begin
            set_coef(9);
            run_packet($sformatf("rnd%0d", r), 1, -1, -1, w0, e0);
        end

        set_coef(0);
        run_packet("abort", 0, -1, 40, w0, e0);
        run_packet("after_rst", 0, -1, -1, w0, e0);
        chk("after_rst word0", w0, 32'hC020_0400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
